// File: rtl/crack_pkg.sv
// Types and key-space defaults shared by the cracker scheduler and the decryption cores.
package crack_pkg;

    localparam int                         DEF_KEY_WIDTH = 24;
    localparam logic [DEF_KEY_WIDTH-1:0]   DEF_KEY_LAST  = 24'h3FFFFF;

    typedef enum logic [2:0] {
        IDLE,
        DISPATCH,
        DRAIN,
        FOUND,
        FAILED
    } sched_state_t;

endpackage

// File: rtl/crack_scheduler_if.sv
// Core-array side of the scheduler: chunk request/grant handshake, hit reporting and halt.
interface crack_scheduler_if
    import crack_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int KEY_WIDTH = DEF_KEY_WIDTH
);

    logic [NUM_CORES-1:0]           core_req;
    logic [NUM_CORES-1:0]           core_grant;
    logic [KEY_WIDTH-1:0]           grant_base;
    logic [KEY_WIDTH-1:0]           grant_last;
    logic [NUM_CORES-1:0]           core_found;
    logic [NUM_CORES*KEY_WIDTH-1:0] core_key;
    logic                           stop;

    modport master (
        input  core_req,
        input  core_found,
        input  core_key,
        output core_grant,
        output grant_base,
        output grant_last,
        output stop
    );

    modport slave (
        output core_req,
        output core_found,
        output core_key,
        input  core_grant,
        input  grant_base,
        input  grant_last,
        input  stop
    );

endinterface

// File: rtl/crack_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt_onehot,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    always_comb begin
        int pos;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        pos        = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!any && req[pos]) begin
                any             = 1'b1;
                gnt_onehot[pos] = 1'b1;
                gnt_idx         = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/crack_scheduler.sv
// Splits the key space into chunks, deals them round-robin to requesting cores,
// and latches the first reported hit or flags exhaustion.
module crack_scheduler
    import crack_pkg::*;
#(
    parameter int                   NUM_CORES = 4,
    parameter int                   KEY_WIDTH = DEF_KEY_WIDTH,
    parameter logic [KEY_WIDTH-1:0] KEY_LAST  = DEF_KEY_LAST,
    parameter int                   CHUNK     = 4096
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    crack_scheduler_if.master            cores,
    output logic                         busy,
    output logic                         cracked,
    output logic                         failed,
    output logic [KEY_WIDTH-1:0]         final_key,
    output logic [$clog2(NUM_CORES)-1:0] winner
);

    localparam int IW  = $clog2(NUM_CORES);
    localparam int NKW = KEY_WIDTH + 1;

    sched_state_t           r_state;
    sched_state_t           w_state_nxt;

    logic [NUM_CORES-1:0]   r_grant;
    logic [KEY_WIDTH-1:0]   r_base;
    logic [KEY_WIDTH-1:0]   r_last;
    logic                   r_stop;
    logic                   r_busy;
    logic                   r_cracked;
    logic                   r_failed;
    logic [KEY_WIDTH-1:0]   r_final_key;
    logic [IW-1:0]          r_winner;
    logic [NKW-1:0]         r_next_key;
    logic [IW-1:0]          r_rr_ptr;

    logic [NUM_CORES-1:0]   w_grant_nxt;
    logic [NUM_CORES-1:0]   w_elig;
    logic [NUM_CORES-1:0]   w_pick_onehot;
    logic [IW-1:0]          w_pick_idx;
    logic                   w_pick_any;
    logic [IW-1:0]          w_ptr_nxt;
    logic [IW-1:0]          w_found_idx;
    logic [KEY_WIDTH-1:0]   w_found_key;
    logic [NKW-1:0]         w_key_adv;
    logic [NKW-1:0]         w_chunk_end;
    logic [KEY_WIDTH-1:0]   w_clip_last;
    logic                   w_drain_done;
    logic                   w_do_start;
    logic                   w_do_grant;
    logic                   w_do_found;
    logic                   w_do_fail;

    // A core granted last cycle still shows req for one more cycle; mask it out.
    assign w_elig = cores.core_req & ~r_grant;

    rr_arbiter #(.N(NUM_CORES)) u_arb (
        .req        (w_elig),
        .ptr        (r_rr_ptr),
        .gnt_onehot (w_pick_onehot),
        .gnt_idx    (w_pick_idx),
        .any        (w_pick_any)
    );

    assign w_ptr_nxt   = (w_pick_idx == IW'(NUM_CORES - 1)) ? '0 : w_pick_idx + IW'(1);
    assign w_key_adv   = r_next_key + NKW'(CHUNK);
    assign w_chunk_end = r_next_key + NKW'(CHUNK - 1);
    assign w_clip_last = (w_chunk_end > {1'b0, KEY_LAST}) ? KEY_LAST : w_chunk_end[KEY_WIDTH-1:0];

    // Scanning downward leaves the lowest-index hit as the winner.
    always_comb begin
        w_found_idx = '0;
        w_found_key = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (cores.core_found[i]) begin
                w_found_idx = IW'(i);
                w_found_key = cores.core_key[i*KEY_WIDTH +: KEY_WIDTH];
            end
        end
    end

    // Everyone idle only counts once the final grant pulse is gone, so the last chunk gets searched.
    assign w_drain_done = (&cores.core_req) && (r_grant == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = '0;
        w_do_start  = 1'b0;
        w_do_grant  = 1'b0;
        w_do_found  = 1'b0;
        w_do_fail   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_do_start  = 1'b1;
                    w_state_nxt = DISPATCH;
                end
            end
            DISPATCH: begin
                if (|cores.core_found) begin
                    w_do_found  = 1'b1;
                    w_state_nxt = FOUND;
                end else if (w_pick_any) begin
                    w_do_grant  = 1'b1;
                    w_grant_nxt = w_pick_onehot;
                    if (w_key_adv > {1'b0, KEY_LAST}) w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (|cores.core_found) begin
                    w_do_found  = 1'b1;
                    w_state_nxt = FOUND;
                end else if (w_drain_done) begin
                    w_do_fail   = 1'b1;
                    w_state_nxt = FAILED;
                end
            end
            FOUND, FAILED: begin
                if (start) begin
                    w_do_start  = 1'b1;
                    w_state_nxt = DISPATCH;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant     <= '0;
            r_base      <= '0;
            r_last      <= '0;
            r_stop      <= 1'b0;
            r_busy      <= 1'b0;
            r_cracked   <= 1'b0;
            r_failed    <= 1'b0;
            r_final_key <= '0;
            r_winner    <= '0;
            r_next_key  <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_grant <= w_grant_nxt;
            r_busy  <= (w_state_nxt == DISPATCH) || (w_state_nxt == DRAIN);
            if (w_do_start) begin
                r_next_key <= '0;
                r_rr_ptr   <= '0;
                r_stop     <= 1'b0;
                r_cracked  <= 1'b0;
                r_failed   <= 1'b0;
            end
            if (w_do_grant) begin
                r_base     <= r_next_key[KEY_WIDTH-1:0];
                r_last     <= w_clip_last;
                r_next_key <= w_key_adv;
                r_rr_ptr   <= w_ptr_nxt;
            end
            if (w_do_found) begin
                r_final_key <= w_found_key;
                r_winner    <= w_found_idx;
                r_stop      <= 1'b1;
                r_cracked   <= 1'b1;
            end
            if (w_do_fail) begin
                r_stop   <= 1'b1;
                r_failed <= 1'b1;
            end
        end
    end

    assign cores.core_grant = r_grant;
    assign cores.grant_base = r_base;
    assign cores.grant_last = r_last;
    assign cores.stop       = r_stop;
    assign busy             = r_busy;
    assign cracked          = r_cracked;
    assign failed           = r_failed;
    assign final_key        = r_final_key;
    assign winner           = r_winner;

endmodule

// File: tb/tb_crack_scheduler.sv
// Bench for crack_scheduler: a 4-core full-space instance and a 2-core instance with a
// clipped key space, driven through one shared stimulus path and one shared monitor view.
module tb_crack_scheduler;
    import crack_pkg::*;

    localparam int CHUNK = 4096;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        sel;
    logic        tbStart;
    logic [3:0]  tbReq;
    logic [3:0]  tbFound;
    logic [95:0] tbKey;

    crack_scheduler_if #(.NUM_CORES(4), .KEY_WIDTH(24)) ifA ();
    crack_scheduler_if #(.NUM_CORES(2), .KEY_WIDTH(24)) ifB ();

    logic        startA, busyA, crackedA, failedA;
    logic        startB, busyB, crackedB, failedB;
    logic [23:0] finalA, finalB;
    logic [1:0]  winnerA;
    logic [0:0]  winnerB;

    assign startA         = tbStart & ~sel;
    assign startB         = tbStart & sel;
    assign ifA.core_req   = sel ? 4'b0000 : tbReq;
    assign ifA.core_found = sel ? 4'b0000 : tbFound;
    assign ifA.core_key   = tbKey;
    assign ifB.core_req   = sel ? tbReq[1:0] : 2'b00;
    assign ifB.core_found = sel ? tbFound[1:0] : 2'b00;
    assign ifB.core_key   = tbKey[47:0];

    crack_scheduler #(.NUM_CORES(4), .KEY_WIDTH(24), .KEY_LAST(24'h3FFFFF), .CHUNK(CHUNK)) dutA (
        .clk(clk), .rst_n(rst_n), .start(startA), .cores(ifA), .busy(busyA),
        .cracked(crackedA), .failed(failedA), .final_key(finalA), .winner(winnerA)
    );

    crack_scheduler #(.NUM_CORES(2), .KEY_WIDTH(24), .KEY_LAST(24'h002800), .CHUNK(CHUNK)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .cores(ifB), .busy(busyB),
        .cracked(crackedB), .failed(failedB), .final_key(finalB), .winner(winnerB)
    );

    logic [3:0]  mGrant;
    logic [23:0] mBase, mLast, mFinal;
    logic        mStop, mBusy, mCracked, mFailed;
    logic [1:0]  mWinner;

    assign mGrant   = sel ? {2'b00, ifB.core_grant} : ifA.core_grant;
    assign mBase    = sel ? ifB.grant_base : ifA.grant_base;
    assign mLast    = sel ? ifB.grant_last : ifA.grant_last;
    assign mStop    = sel ? ifB.stop : ifA.stop;
    assign mBusy    = sel ? busyB : busyA;
    assign mCracked = sel ? crackedB : crackedA;
    assign mFailed  = sel ? failedB : failedA;
    assign mFinal   = sel ? finalB : finalA;
    assign mWinner  = sel ? {1'b0, winnerB} : winnerA;

    int nChecks = 0;
    int nErrors = 0;

    typedef struct {
        int          core;
        logic [23:0] base;
        logic [23:0] last;
    } grant_t;

    grant_t expQ[$];

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] found, input logic [95:0] key);
        tbReq   = req;
        tbFound = found;
        tbKey   = key;
    endtask

    task automatic pushExp(input int core, input logic [23:0] base, input logic [23:0] last);
        grant_t g;
        g.core = core;
        g.base = base;
        g.last = last;
        expQ.push_back(g);
    endtask

    task automatic pulseStart();
        tbStart = 1'b1;
        @(negedge clk);
        tbStart = 1'b0;
    endtask

    task automatic checkReset(input string pfx);
        checkOutput({pfx, "_grant"},   32'(mGrant),   0);
        checkOutput({pfx, "_base"},    32'(mBase),    0);
        checkOutput({pfx, "_last"},    32'(mLast),    0);
        checkOutput({pfx, "_stop"},    32'(mStop),    0);
        checkOutput({pfx, "_busy"},    32'(mBusy),    0);
        checkOutput({pfx, "_cracked"}, 32'(mCracked), 0);
        checkOutput({pfx, "_failed"},  32'(mFailed),  0);
        checkOutput({pfx, "_final"},   32'(mFinal),   0);
        checkOutput({pfx, "_winner"},  32'(mWinner),  0);
    endtask

    // Core model: rearm<0 keeps req high, 0 drops it for good, >0 re-raises it after that many cycles.
    task automatic collectGrants(input int n, input int budget, input int rearm,
                                 input bit noRepeat, output int iters);
        int         got;
        int         hold[4];
        logic [3:0] prev;
        grant_t     e;
        got   = 0;
        prev  = '0;
        iters = 0;
        for (int i = 0; i < 4; i++) hold[i] = 0;
        while (got < n && iters < budget) begin
            @(negedge clk);
            iters++;
            for (int i = 0; i < 4; i++) begin
                if (hold[i] > 0) begin
                    hold[i]--;
                    if (hold[i] == 0) tbReq[i] = 1'b1;
                end
            end
            if (mGrant != 4'b0000) begin
                if (expQ.size() == 0) begin
                    checkOutput("grant_unexpected", 32'(mGrant), 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("grant_core", 32'(mGrant), 32'd1 << e.core);
                    checkOutput("grant_base", 32'(mBase), 32'(e.base));
                    checkOutput("grant_last", 32'(mLast), 32'(e.last));
                end
                if (noRepeat) checkOutput("grant_repeat", 32'((mGrant & prev) != 4'b0000), 0);
                prev = mGrant;
                got++;
                if (rearm >= 0) begin
                    for (int i = 0; i < 4; i++) begin
                        if (mGrant[i]) begin
                            tbReq[i] = 1'b0;
                            hold[i]  = rearm;
                        end
                    end
                end
            end else begin
                prev = '0;
            end
        end
        checkOutput("grant_count", 32'(got), 32'(n));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   iters;
        logic [95:0] key;

        sel     = 1'b0;
        tbStart = 1'b0;
        rst_n   = 1'b0;
        applyStimulus(4'b0000, 4'b0000, '0);

        // Reset values on both instances.
        #3;
        checkReset("rstA");
        sel = 1'b1;
        #1;
        checkReset("rstB");
        sel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic dispatch: all four cores requesting.
        $display("[TB] basic dispatch");
        tbReq = 4'b1111;
        pushExp(0, 24'h000000, 24'h000FFF);
        pushExp(1, 24'h001000, 24'h001FFF);
        pushExp(2, 24'h002000, 24'h002FFF);
        pushExp(3, 24'h003000, 24'h003FFF);
        pulseStart();
        collectGrants(4, 10, 0, 1'b0, iters);
        checkOutput("dispatch_cycles", 32'(iters), 4);
        checkOutput("dispatch_busy", 32'(mBusy), 1);

        // Round-robin fairness: only cores 1 and 3 hold req.
        $display("[TB] round-robin fairness");
        tbReq = 4'b1010;
        pushExp(1, 24'h004000, 24'h004FFF);
        pushExp(3, 24'h005000, 24'h005FFF);
        pushExp(1, 24'h006000, 24'h006FFF);
        pushExp(3, 24'h007000, 24'h007FFF);
        collectGrants(4, 10, -1, 1'b1, iters);
        checkOutput("rr_cycles", 32'(iters), 4);
        tbReq = 4'b0000;

        // Hit on core 2.
        $display("[TB] hit on core 2");
        key = '0;
        key[0*24 +: 24] = 24'h00ABCD;
        key[2*24 +: 24] = 24'h0A3C51;
        applyStimulus(4'b0000, 4'b0100, key);
        @(negedge clk);
        tbFound = 4'b0000;
        checkOutput("hit_stop", 32'(mStop), 1);
        checkOutput("hit_cracked", 32'(mCracked), 1);
        checkOutput("hit_key", 32'(mFinal), 32'h0A3C51);
        checkOutput("hit_winner", 32'(mWinner), 2);
        checkOutput("hit_busy", 32'(mBusy), 0);
        checkOutput("hit_failed", 32'(mFailed), 0);
        key[0*24 +: 24] = 24'h123456;
        applyStimulus(4'b0000, 4'b0001, key);
        @(negedge clk);
        tbFound = 4'b0000;
        @(negedge clk);
        checkOutput("late_hit_key", 32'(mFinal), 32'h0A3C51);
        checkOutput("late_hit_winner", 32'(mWinner), 2);
        checkOutput("late_hit_cracked", 32'(mCracked), 1);

        // Restart from FOUND, then simultaneous hits on 1 and 3 while core 0 requests.
        $display("[TB] simultaneous hit plus request");
        pulseStart();
        checkOutput("restart_stop", 32'(mStop), 0);
        checkOutput("restart_cracked", 32'(mCracked), 0);
        checkOutput("restart_busy", 32'(mBusy), 1);
        key = '0;
        key[1*24 +: 24] = 24'h111111;
        key[3*24 +: 24] = 24'h333333;
        applyStimulus(4'b0001, 4'b1010, key);
        @(negedge clk);
        applyStimulus(4'b0000, 4'b0000, key);
        checkOutput("sim_grant", 32'(mGrant), 0);
        checkOutput("sim_winner", 32'(mWinner), 1);
        checkOutput("sim_key", 32'(mFinal), 32'h111111);
        checkOutput("sim_cracked", 32'(mCracked), 1);
        checkOutput("sim_stop", 32'(mStop), 1);
        @(negedge clk);
        checkOutput("sim_grant_after", 32'(mGrant), 0);

        // Asynchronous reset in the middle of dispatching.
        $display("[TB] async reset mid-dispatch");
        tbReq = 4'b1111;
        pushExp(0, 24'h000000, 24'h000FFF);
        pushExp(1, 24'h001000, 24'h001FFF);
        pulseStart();
        collectGrants(2, 10, 0, 1'b0, iters);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("async");
        @(negedge clk);
        rst_n = 1'b1;
        tbReq = 4'b0000;
        @(negedge clk);
        checkOutput("post_reset_busy", 32'(mBusy), 0);
        checkOutput("post_reset_grant", 32'(mGrant), 0);

        // Exhaustion on the 2-core instance with a short final chunk.
        $display("[TB] exhaustion with clipped key space");
        sel   = 1'b1;
        tbReq = 4'b0011;
        pushExp(0, 24'h000000, 24'h000FFF);
        pushExp(1, 24'h001000, 24'h001FFF);
        pushExp(0, 24'h002000, 24'h002800);
        pulseStart();
        collectGrants(3, 20, 2, 1'b0, iters);
        tbReq = 4'b0010;
        for (int i = 0; i < 4; i++) @(negedge clk);
        checkOutput("drain_failed", 32'(mFailed), 0);
        checkOutput("drain_busy", 32'(mBusy), 1);
        checkOutput("drain_grant", 32'(mGrant), 0);
        checkOutput("drain_stop", 32'(mStop), 0);
        tbReq = 4'b0011;
        iters = 0;
        do begin
            @(negedge clk);
            iters++;
        end while (!mFailed && iters < 10);
        checkOutput("fail_seen", 32'(mFailed), 1);
        checkOutput("fail_stop", 32'(mStop), 1);
        checkOutput("fail_busy", 32'(mBusy), 0);
        checkOutput("fail_cracked", 32'(mCracked), 0);

        // Restart after FAILED begins again at key 0.
        $display("[TB] restart after failure");
        pulseStart();
        checkOutput("restart2_failed", 32'(mFailed), 0);
        checkOutput("restart2_stop", 32'(mStop), 0);
        checkOutput("restart2_busy", 32'(mBusy), 1);
        pushExp(0, 24'h000000, 24'h000FFF);
        pushExp(1, 24'h001000, 24'h001FFF);
        collectGrants(2, 10, 0, 1'b0, iters);
        checkOutput("leftover_expected", 32'(expQ.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
